// File: rtl/snake_body_engine.sv
// snake_body_engine: snake game-logic stage feeding the VGA display.
// Holds the body on a GRID_W x GRID_H cell grid, advances it one cell per
// step_tick, detects apple/wall/self hits and classifies each VGA pixel
// (00 empty, 01 head, 10 body, 11 wall) with one clock of latency.
// Optional feature: define SNAKE_WRAP_EN to remove the walls and let the
// head wrap around the grid edges (only a self hit is then fatal).
module snake_body_engine #(
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 3,
    parameter int unsigned GRID_W   = 40,
    parameter int unsigned GRID_H   = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] dir,
    input  logic       step_tick,
    input  logic [5:0] apple_x,
    input  logic [5:0] apple_y,
    input  logic [9:0] x_pos,
    input  logic [9:0] y_pos,
    output logic [1:0] snake,
    output logic [5:0] length,
    output logic       eat,
    output logic       dead
);

    localparam int unsigned CW = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] MOVE = 2'd2;
    localparam logic [1:0] DEAD = 2'd3;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_DOWN  = 2'b01;
    localparam logic [1:0] DIR_LEFT  = 2'b10;
    localparam logic [1:0] DIR_RIGHT = 2'b11;

    localparam logic [CW-1:0] START_X = CW'(20);
    localparam logic [CW-1:0] START_Y = CW'(15);
    localparam logic [CW-1:0] LAST_X  = CW'(GRID_W - 1);
    localparam logic [CW-1:0] LAST_Y  = CW'(GRID_H - 1);

    logic [1:0]    state;
    logic [1:0]    next_state;
    logic [1:0]    cur_dir;
    logic [CW-1:0] seg_x [MAX_LEN];
    logic [CW-1:0] seg_y [MAX_LEN];

    logic [CW-1:0] nh_x;
    logic [CW-1:0] nh_y;
    logic [CW-1:0] self_lim;
    logic          wall_hit;
    logic          self_hit;
    logic          apple_hit;
    logic          grow;
    logic          hit;
    logic          reverse;

    logic [CW-1:0] cell_x;
    logic [CW-1:0] cell_y;
    logic          in_range;
    logic          border;
    logic          head_hit;
    logic          body_hit;
    logic [1:0]    pix_class;

    // A request for the exact opposite direction is a reversal and is ignored
    assign reverse = (dir[1] == cur_dir[1]) && (dir[0] != cur_dir[0]);

    // Candidate head position and the hit/grow decisions for the MOVE cycle
    always_comb begin
        nh_x = seg_x[0];
        nh_y = seg_y[0];
        case (cur_dir)
            DIR_UP:   nh_y = seg_y[0] - CW'(1);
            DIR_DOWN: nh_y = seg_y[0] + CW'(1);
            DIR_LEFT: nh_x = seg_x[0] - CW'(1);
            default:  nh_x = seg_x[0] + CW'(1);
        endcase
`ifdef SNAKE_WRAP_EN
        if (cur_dir == DIR_UP    && seg_y[0] == '0)     nh_y = LAST_Y;
        if (cur_dir == DIR_DOWN  && seg_y[0] == LAST_Y) nh_y = '0;
        if (cur_dir == DIR_LEFT  && seg_x[0] == '0)     nh_x = LAST_X;
        if (cur_dir == DIR_RIGHT && seg_x[0] == LAST_X) nh_x = '0;
        wall_hit = 1'b0;
`else
        wall_hit = (nh_x == '0) || (nh_x == LAST_X) ||
                   (nh_y == '0) || (nh_y == LAST_Y);
`endif
        apple_hit = (nh_x == apple_x) && (nh_y == apple_y);
        grow      = apple_hit && (length < CW'(MAX_LEN));
        // The tail vacates on a plain move, but stays put when growing
        self_lim  = grow ? length : (length - CW'(1));
        self_hit  = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((CW'(i) < self_lim) && (seg_x[i] == nh_x) && (seg_y[i] == nh_y)) begin
                self_hit = 1'b1;
            end
        end
        hit = wall_hit || self_hit;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // FSM next-state logic
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = RUN;
            RUN:     if (step_tick) next_state = MOVE;
            MOVE:    next_state = hit ? DEAD : RUN;
            default: if (start) next_state = RUN;
        endcase
    end

    // Body, length and direction latch; restart from DEAD reloads the start body
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? CW'(START_X - CW'(i)) : '0;
                seg_y[i] <= (i < INIT_LEN) ? START_Y : '0;
            end
            length  <= CW'(INIT_LEN);
            cur_dir <= DIR_RIGHT;
        end else if (state == DEAD && start) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x[i] <= (i < INIT_LEN) ? CW'(START_X - CW'(i)) : '0;
                seg_y[i] <= (i < INIT_LEN) ? START_Y : '0;
            end
            length  <= CW'(INIT_LEN);
            cur_dir <= DIR_RIGHT;
        end else if (state == MOVE && !hit) begin
            for (int unsigned i = 1; i < MAX_LEN; i++) begin
                seg_x[i] <= seg_x[i-1];
                seg_y[i] <= seg_y[i-1];
            end
            seg_x[0] <= nh_x;
            seg_y[0] <= nh_y;
            if (grow) begin
                length <= length + CW'(1);
            end
        end else if (state == RUN && !reverse) begin
            cur_dir <= dir;
        end
    end

    // Pixel classification of the cell under the current VGA coordinate
    always_comb begin
        cell_x   = x_pos[9:4];
        cell_y   = y_pos[9:4];
        in_range = (x_pos < 10'd640) && (y_pos < 10'd480);
`ifdef SNAKE_WRAP_EN
        border   = 1'b0;
`else
        border   = (cell_x == '0) || (cell_x == LAST_X) ||
                   (cell_y == '0) || (cell_y == LAST_Y);
`endif
        head_hit = (cell_x == seg_x[0]) && (cell_y == seg_y[0]);
        body_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_LEN; i++) begin
            if ((CW'(i) < length) && (seg_x[i] == cell_x) && (seg_y[i] == cell_y)) begin
                body_hit = 1'b1;
            end
        end
        pix_class = 2'b00;
        if (!in_range) begin
            pix_class = 2'b00;
        end else if (border) begin
            pix_class = 2'b11;
        end else if (head_hit) begin
            pix_class = 2'b01;
        end else if (body_hit) begin
            pix_class = 2'b10;
        end
    end

    // Registered outputs: pixel class, eat pulse and dead flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            snake <= 2'b00;
            eat   <= 1'b0;
            dead  <= 1'b0;
        end else begin
            snake <= pix_class;
            eat   <= (state == MOVE) && !hit && apple_hit;
            dead  <= (next_state == DEAD);
        end
    end

endmodule
